regfile_wb_arbiter: RTL

- Shares the single register-file write port between two writeback sources: A (ALU/execute) and M (memory/load unit).
- Registers the winning write for one cycle before driving the write port.
- Maintains a per-register busy scoreboard. Issue logic allocates destinations into it; committed writes clear it.
- Reports read hazards for the two register-file read ports, so decode can stall until the write has landed.

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU (A) and the
//   memory/load unit (M) writeback sources, registers the winning write for
//   one cycle, and keeps a per-register busy scoreboard so decode can stall
//   on reads of registers whose write has not yet landed.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   a_valid/a_reg/a_data/a_ready writeback source A handshake
//   m_valid/m_reg/m_data/m_ready writeback source M handshake
//   alloc_valid/alloc_reg        issue-stage destination allocation
//   rd_reg1/rd_reg2              read-port indices to hazard-check
//   rd_hazard1/rd_hazard2        read index has an uncommitted write
//   rf_wr_en/rf_wr_reg/rf_wr_data registered register-file write port
//   busy_cnt                     number of busy registers
//   alloc_err                    sticky: allocation to an already-busy reg
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_reg,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              rd_hazard1,
  output logic              rd_hazard2,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              alloc_err
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {PRIO_A, PRIO_M} prio_t;

  prio_t             prio, prio_next;
  logic              a_hs, m_hs;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic [NREGS-1:0]  busy, busy_next;
  logic [ADDR_W:0]   cnt_next;
  logic              alloc_conflict;

  // Round-robin priority register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio <= PRIO_A;
    else      prio <= prio_next;
  end

  // Grant logic. Under contention the pointer moves to the loser, so the
  // two sources alternate; uncontended grants leave the pointer alone.
  always_comb begin
    a_ready   = a_valid && (!m_valid || (prio == PRIO_A));
    m_ready   = m_valid && (!a_valid || (prio == PRIO_M));
    prio_next = prio;
    if (a_valid && m_valid)
      prio_next = (prio == PRIO_A) ? PRIO_M : PRIO_A;
  end

  assign a_hs     = a_valid && a_ready;
  assign m_hs     = m_valid && m_ready;
  assign win_reg  = a_hs ? a_reg  : m_reg;
  assign win_data = a_hs ? a_data : m_data;

  // Write stage. Register 0 is hardwired, so a write to it passes through
  // with the enable held low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end else if (a_hs || m_hs) begin
      rf_wr_en   <= (win_reg != '0);
      rf_wr_reg  <= win_reg;
      rf_wr_data <= win_data;
    end else begin
      rf_wr_en   <= 1'b0;
    end
  end

  // Scoreboard next state. The set is applied after the clear so an
  // allocation at the commit edge of the same register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (rf_wr_en)
      busy_next[rf_wr_reg] = 1'b0;
    if (alloc_valid && (alloc_reg != '0))
      busy_next[alloc_reg] = 1'b1;

    alloc_conflict = alloc_valid && (alloc_reg != '0) && busy[alloc_reg] &&
                     !(rf_wr_en && (rf_wr_reg == alloc_reg));

    cnt_next = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      busy_cnt  <= '0;
      alloc_err <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      if (alloc_conflict)
        alloc_err <= 1'b1;
    end
  end

  // No bypass: hazards follow the registered scoreboard only.
  assign rd_hazard1 = busy[rd_reg1] && (rd_reg1 != '0);
  assign rd_hazard2 = busy[rd_reg2] && (rd_reg2 != '0);

endmodule
